// File: rtl/chacha_qr_sequencer.sv
// Sequences ChaCha quarter-round requests (column round, then diagonal round) for a
// programmable number of double rounds, steering an external 2-bit index counter.
// MAX_DR must fit the 4-bit num_dr/dr_done range (0..15).
module chacha_qr_sequencer #(
    parameter int unsigned MAX_DR = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] num_dr,
    input  logic [1:0] start_index,
    input  logic       qr_ack,
    input  logic [1:0] cnt_value,
    output logic       cnt_set0,
    output logic       cnt_lock,
    output logic [1:0] cnt_init_value,
    output logic       cnt_step,
    output logic       qr_req,
    output logic [1:0] qr_index,
    output logic       diag_sel,
    output logic [3:0] dr_done,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned DR_W  = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        COL  = 3'd2,
        DIAG = 3'd3,
        FIN  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [DR_W-1:0]  num_q, num_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] shadow_q, shadow_d;
    logic [1:0]       qr_cnt_q, qr_cnt_d;
    logic [DR_W-1:0]  dr_done_q, dr_done_d;
    logic             err_q, err_d;
    logic             skip_q, skip_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             qr_req_q, qr_req_d;
    logic             diag_q, diag_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] init_q, init_d;

    logic [DR_W-1:0]  num_clamped_c;
    logic             step_c;
    logic             set0_c;
    logic             lock_c;
    logic             mismatch_c;

    // Abort pre-empts both an acknowledge and a pending counter load.
    assign num_clamped_c = (32'(num_dr) > MAX_DR) ? DR_W'(MAX_DR) : num_dr;
    assign step_c        = qr_req_q & qr_ack & ~abort;
    assign set0_c        = abort & busy_q;
    assign lock_c        = lock_q & ~abort;
    assign mismatch_c    = qr_req_q & ~skip_q & (cnt_value != shadow_q);

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        qr_cnt_d  = qr_cnt_q;
        dr_done_d = dr_done_q;
        err_d     = err_q | mismatch_c;

        if ((state_q != IDLE) && abort) begin
            state_d  = IDLE;
            shadow_d = '0;
            qr_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_d     = 1'b0;
                        dr_done_d = '0;
                        num_d     = num_clamped_c;
                        idx_d     = start_index;
                        state_d   = (num_clamped_c == '0) ? FIN : LOAD;
                    end
                end
                LOAD: begin
                    shadow_d = idx_q;
                    qr_cnt_d = '0;
                    state_d  = COL;
                end
                COL, DIAG: begin
                    if (step_c) begin
                        shadow_d = shadow_q + IDX_W'(1);
                        qr_cnt_d = qr_cnt_q + 2'd1;
                        // Four acks wrap the shadow back to the start index
                        if (qr_cnt_q == 2'd3) begin
                            if (state_q == COL) begin
                                state_d = DIAG;
                            end else begin
                                dr_done_d = dr_done_q + DR_W'(1);
                                state_d   = (dr_done_d == num_q) ? FIN : COL;
                            end
                        end
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        busy_d   = (state_d != IDLE);
        done_d   = (state_d == FIN);
        qr_req_d = (state_d == COL) || (state_d == DIAG);
        diag_d   = (state_d == DIAG);
        lock_d   = (state_d == LOAD);
        init_d   = (state_d == LOAD) ? idx_d : '0;
        // The counter lags one cycle after any command it receives
        skip_d   = step_c | lock_c;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            num_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            qr_cnt_q  <= '0;
            dr_done_q <= '0;
            err_q     <= 1'b0;
            skip_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            qr_req_q  <= 1'b0;
            diag_q    <= 1'b0;
            lock_q    <= 1'b0;
            init_q    <= '0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            qr_cnt_q  <= qr_cnt_d;
            dr_done_q <= dr_done_d;
            err_q     <= err_d;
            skip_q    <= skip_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            qr_req_q  <= qr_req_d;
            diag_q    <= diag_d;
            lock_q    <= lock_d;
            init_q    <= init_d;
        end
    end

    assign cnt_set0       = set0_c;
    assign cnt_lock       = lock_c;
    assign cnt_init_value = init_q;
    assign cnt_step       = step_c;
    assign qr_req         = qr_req_q;
    assign qr_index       = shadow_q;
    assign diag_sel       = diag_q;
    assign dr_done        = dr_done_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_chacha_qr_sequencer.sv
// Directed, table-driven bench for chacha_qr_sequencer with a behavioural index-counter model.
module tb_chacha_qr_sequencer;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [3:0] num_dr;
    logic [1:0] start_index;
    logic       qr_ack;
    logic [1:0] cnt_value;
    logic       cnt_set0;
    logic       cnt_lock;
    logic [1:0] cnt_init_value;
    logic       cnt_step;
    logic       qr_req;
    logic [1:0] qr_index;
    logic       diag_sel;
    logic [3:0] dr_done;
    logic       busy;
    logic       done;
    logic       err;

    logic [1:0] cnt_m;
    logic       corrupt;

    int n_chk  = 0;
    int n_pass = 0;

    chacha_qr_sequencer #(.MAX_DR(10)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .abort         (abort),
        .num_dr        (num_dr),
        .start_index   (start_index),
        .qr_ack        (qr_ack),
        .cnt_value     (cnt_value),
        .cnt_set0      (cnt_set0),
        .cnt_lock      (cnt_lock),
        .cnt_init_value(cnt_init_value),
        .cnt_step      (cnt_step),
        .qr_req        (qr_req),
        .qr_index      (qr_index),
        .diag_sel      (diag_sel),
        .dr_done       (dr_done),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 2-bit index counter; corrupt makes it report one ahead.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)      cnt_m <= 2'd0;
        else if (cnt_set0) cnt_m <= 2'd0;
        else if (cnt_lock) cnt_m <= cnt_init_value;
        else if (cnt_step) cnt_m <= cnt_m + 2'd1;
    end
    assign cnt_value = cnt_m + {1'b0, corrupt};

    typedef struct {
        int n;         // num_dr applied
        int si;        // start_index applied
        bit stall;     // every odd-numbered request gets 3 ack-low cycles first
        bit corr;      // counter reports shadow+1 while in the column round
        int abort_k;   // request number aborted together with its ack (-1: none)
        bit hold;      // keep start high while the run is busy
        bit abs;       // assert abort together with start in IDLE
        int exp_cyc;   // cycle (after the start edge) showing done; 0 = never
        int exp_drd;
        int exp_err;
        int exp_locks;
        int exp_steps;
        int exp_set0;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input int n, input int si, input bit stall, input bit corr,
                                input int abort_k, input bit hold, input bit abs,
                                input int exp_cyc, input int exp_drd, input int exp_err,
                                input int exp_locks, input int exp_steps, input int exp_set0);
        vec_t v;
        v.n = n; v.si = si; v.stall = stall; v.corr = corr; v.abort_k = abort_k;
        v.hold = hold; v.abs = abs; v.exp_cyc = exp_cyc; v.exp_drd = exp_drd;
        v.exp_err = exp_err; v.exp_locks = exp_locks; v.exp_steps = exp_steps;
        v.exp_set0 = exp_set0;
        return v;
    endfunction

    function automatic int all_outs();
        return int'({cnt_set0, cnt_lock, cnt_init_value, cnt_step, qr_req, qr_index,
                     diag_sel, dr_done, busy, done, err});
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int cyc = 0, k = 0, stall_cnt = 0, dones = 0;
        int locks = 0, steps = 0, set0s = 0, overlap = 0;
        int abort_cyc = -1, end_cyc = -1;
        bit exp_step, fin = 1'b0;
        @(negedge clk);
        num_dr      = 4'(v.n);
        start_index = 2'(v.si);
        start       = 1'b1;
        abort       = v.abs;
        qr_ack      = 1'b0;
        corrupt     = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start    = v.hold && (dones == 0) && (abort_cyc < 0);
            abort    = 1'b0;
            qr_ack   = 1'b0;
            corrupt  = 1'b0;
            exp_step = 1'b0;
            if (qr_req) begin
                chk($sformatf("v%0d_qr_index_k%0d", id, k), int'(qr_index), (v.si + k) % 4);
                chk($sformatf("v%0d_diag_sel_k%0d", id, k), int'(diag_sel), (k / 4) % 2);
                corrupt = v.corr && !diag_sel;
                if (v.stall && (k % 2 == 1) && (stall_cnt < 3)) stall_cnt++;
                else qr_ack = 1'b1;
                if (k == v.abort_k) begin
                    abort     = 1'b1;
                    abort_cyc = cyc;
                end
                exp_step = qr_ack && !abort;
            end
            #1;
            chk($sformatf("v%0d_cnt_step_c%0d", id, cyc), int'(cnt_step), int'(exp_step));
            if (cyc == 1) chk($sformatf("v%0d_lock_at_load", id), int'(cnt_lock), int'(v.n != 0));
            if (cnt_lock) begin
                locks++;
                chk($sformatf("v%0d_init_value", id), int'(cnt_init_value), v.si);
            end
            if (cnt_step) steps++;
            if (cnt_set0) set0s++;
            if (int'(cnt_lock) + int'(cnt_step) + int'(cnt_set0) > 1) overlap++;
            if (exp_step) begin
                k++;
                stall_cnt = 0;
            end
            if (done) begin
                dones++;
                if (dones == 1) begin
                    chk($sformatf("v%0d_done_cycle", id), cyc, v.exp_cyc);
                    chk($sformatf("v%0d_dr_done", id), int'(dr_done), v.exp_drd);
                    chk($sformatf("v%0d_err", id), int'(err), v.exp_err);
                    chk($sformatf("v%0d_busy_at_done", id), int'(busy), 1);
                    end_cyc = cyc + 1;
                end
            end
            if (abort_cyc > 0 && cyc == abort_cyc)
                chk($sformatf("v%0d_abort_set0", id), int'(cnt_set0), 1);
            if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
                chk($sformatf("v%0d_abort_busy", id), int'(busy), 0);
                chk($sformatf("v%0d_abort_dr_done", id), int'(dr_done), v.exp_drd);
                chk($sformatf("v%0d_abort_shadow", id), int'(qr_index), 0);
                chk($sformatf("v%0d_abort_counter", id), int'(cnt_m), 0);
                end_cyc = cyc + 3;
            end
            if (cyc == end_cyc) begin
                chk($sformatf("v%0d_idle_busy", id), int'(busy), 0);
                chk($sformatf("v%0d_idle_done", id), int'(done), 0);
                fin = 1'b1;
            end
            if (cyc >= 400 && !fin) begin
                $display("FAIL v%0d_timeout: no completion after %0d cycles, expected done at %0d",
                         id, cyc, v.exp_cyc);
                n_chk++;
                fin = 1'b1;
            end
        end
        chk($sformatf("v%0d_done_pulses", id), dones, (v.exp_cyc != 0) ? 1 : 0);
        chk($sformatf("v%0d_lock_pulses", id), locks, v.exp_locks);
        chk($sformatf("v%0d_step_pulses", id), steps, v.exp_steps);
        chk($sformatf("v%0d_set0_pulses", id), set0s, v.exp_set0);
        chk($sformatf("v%0d_cmd_overlap", id), overlap, 0);
    endtask

    initial begin
        // n si stall corr abort_k hold abs | exp_cyc drd err locks steps set0
        vecs[0] = mk(1,  2, 0, 0, -1, 0, 0, 10, 1,  0, 1, 8,  0);
        // eight odd-numbered requests each wait three extra cycles: 1+16+24+1
        vecs[1] = mk(2,  3, 1, 0, -1, 1, 0, 42, 2,  0, 1, 16, 0);
        // request 13 sits in the diagonal round of the second double round
        vecs[2] = mk(2,  1, 0, 0, 13, 0, 0, 0,  1,  0, 1, 13, 1);
        // four stalled requests: 1+8+12+1
        vecs[3] = mk(1,  0, 1, 1, -1, 0, 0, 22, 1,  1, 1, 8,  0);
        vecs[4] = mk(1,  1, 0, 0, -1, 0, 1, 10, 1,  0, 1, 8,  0);
        vecs[5] = mk(0,  2, 0, 0, -1, 0, 0, 1,  0,  0, 0, 0,  0);
        vecs[6] = mk(15, 3, 0, 0, -1, 0, 0, 82, 10, 0, 1, 80, 0);
        vecs[7] = mk(3,  0, 0, 0, -1, 0, 0, 26, 3,  0, 1, 24, 0);

        reset_n     = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        num_dr      = 4'd0;
        start_index = 2'd0;
        qr_ack      = 1'b0;
        corrupt     = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset dropped in the middle of a column round
        @(negedge clk);
        num_dr      = 4'd1;
        start_index = 2'd2;
        start       = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start  = 1'b0;
            qr_ack = 1'b1;
        end
        #1;
        chk("midrun_qr_req", int'(qr_req), 1);
        chk("midrun_diag_sel", int'(diag_sel), 0);
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("reset_hold_outputs", all_outs(), 0);
        end
        @(negedge clk);
        qr_ack  = 1'b0;
        reset_n = 1'b1;
        run_vec(vecs[7], 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
